// File: rtl/prbs_stream_checker.sv
// rtl/prbs_stream_checker.sv - self-synchronising serial PRBS checker with lock tracking and error count
// Optional macro PRBS_CHK_BITCNT_EN adds a saturating bit_count of valid bits seen while locked.
module prbs_stream_checker #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
    parameter int               ERR_W       = 16,
    parameter int               LOCK_CNT    = 16,
    parameter int               WINDOW      = 64,
    parameter int               LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
`ifdef PRBS_CHK_BITCNT_EN
    output logic [ERR_W-1:0] bit_count,
`endif
    output logic [1:0]       state_o
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int LW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_q, win_d;
    logic [LW-1:0]    loss_q, loss_d, loss_base;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_count_q;
    logic             pred, err_ev, count_err, win_wrap;

    assign pred     = ^(sr_q & TAPS);
    assign sr_shift = {sr_q[WIDTH-2:0], bit_in};

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        loss_d    = loss_q;
        err_ev    = 1'b0;
        count_err = 1'b0;
        win_wrap  = 1'b0;
        loss_base = loss_q;
        if (bit_valid) begin
            case (state_q)
                SEED: begin
                    sr_d   = sr_shift;
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FW'(WIDTH - 1)) begin
                        // An all-zero register is the LFSR lockup state; keep seeding.
                        if (sr_shift != '0) state_d = CHECK;
                        else                fill_d  = '0;
                    end
                end
                CHECK: begin
                    sr_d = sr_shift;
                    if (bit_in == pred) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            loss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        fill_d  = '0;
                        state_d = SEED;
                    end
                end
                LOCKED: begin
                    // Flywheel: the register runs on its own prediction, so line errors never corrupt it.
                    sr_d      = {sr_q[WIDTH-2:0], pred};
                    err_ev    = (bit_in != pred);
                    win_wrap  = (win_q == WW'(WINDOW - 1));
                    win_d     = win_wrap ? '0 : win_q + 1'b1;
                    loss_base = win_wrap ? '0 : loss_q;
                    loss_d    = loss_base;
                    if (err_ev) begin
                        if (loss_base == LW'(LOSS_THRESH - 1)) begin
                            state_d = SEED;
                            fill_d  = '0;
                            match_d = '0;
                            win_d   = '0;
                            loss_d  = '0;
                        end else begin
                            loss_d    = loss_base + 1'b1;
                            count_err = 1'b1;
                        end
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            loss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            loss_q      <= loss_d;
            err_pulse_q <= err_ev;
            if (clear_err)
                err_count_q <= '0;
            else if (count_err && (err_count_q != '1))
                err_count_q <= err_count_q + 1'b1;
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [ERR_W-1:0] bit_count_q;

    always_ff @(posedge clk) begin
        if (rst)
            bit_count_q <= '0;
        else if (clear_err)
            bit_count_q <= '0;
        else if (bit_valid && (state_q == LOCKED) && (bit_count_q != '1))
            bit_count_q <= bit_count_q + 1'b1;
    end

    assign bit_count = bit_count_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// tb/tb_prbs_stream_checker.sv - self-checking bench for prbs_stream_checker (ERR_W=16 and ERR_W=4 instances)
module tb_prbs_stream_checker;

    localparam logic [7:0] TAPS_M = 8'hB8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, bit_valid, bit_in, clear_err;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
    logic [1:0]  state_o, state_o4;
`ifdef PRBS_CHK_BITCNT_EN
    logic [15:0] bit_count;
    logic [3:0]  bit_count4;
`endif

    prbs_stream_checker dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear_err(clear_err),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
`ifdef PRBS_CHK_BITCNT_EN
        .bit_count(bit_count),
`endif
        .state_o(state_o)
    );

    prbs_stream_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear_err(clear_err),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4),
`ifdef PRBS_CHK_BITCNT_EN
        .bit_count(bit_count4),
`endif
        .state_o(state_o4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=seed 1=check 2=locked, history of received/predicted bits, newest first.
    int m_mode, m_fill, m_match, m_win, m_loss, m_cnt, m_cnt4, m_bc, m_bc4;
    bit m_pulse;
    int hist[$];

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < 8; i++) hist.push_back(0);
        m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_loss = 0;
        m_cnt = 0; m_cnt4 = 0; m_bc = 0; m_bc4 = 0; m_pulse = 0;
    endtask

    function automatic int m_pred();
        int p = 0;
        for (int k = 0; k < 8; k++) if (TAPS_M[k]) p ^= hist[k];
        return p;
    endfunction

    task automatic push_bit(input int x);
        hist.push_front(x);
        void'(hist.pop_back());
    endtask

    task automatic model_step(input bit r, input bit v, input bit b, input bit c);
        int p, s;
        if (r) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (c) begin
            m_cnt = 0; m_cnt4 = 0; m_bc = 0; m_bc4 = 0;
        end
        if (!v) return;
        p = m_pred();
        case (m_mode)
            0: begin
                push_bit(int'(b));
                m_fill++;
                if (m_fill == 8) begin
                    s = 0;
                    foreach (hist[k]) s += hist[k];
                    if (s == 0) m_fill = 0;
                    else        m_mode = 1;
                end
            end
            1: begin
                push_bit(int'(b));
                if (int'(b) == p) begin
                    m_match++;
                    if (m_match == 16) begin
                        m_mode = 2; m_win = 0; m_loss = 0;
                    end
                end else begin
                    m_match = 0; m_fill = 0; m_mode = 0;
                end
            end
            default: begin
                push_bit(p);
                if (!c) begin
                    if (m_bc < 65535) m_bc++;
                    if (m_bc4 < 15) m_bc4++;
                end
                m_pulse = (int'(b) != p);
                m_win++;
                if (m_win == 64) begin
                    m_win = 0; m_loss = 0;
                end
                if (m_pulse) begin
                    m_loss++;
                    if (m_loss == 4) begin
                        m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_loss = 0;
                    end else if (!c) begin
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt4 < 15) m_cnt4++;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state_o", 32'(state_o), 32'(m_mode));
        check("locked", 32'(locked), 32'(m_mode == 2));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_count", 32'(err_count), 32'(m_cnt));
        check("state_o_w4", 32'(state_o4), 32'(m_mode));
        check("err_pulse_w4", 32'(err_pulse4), 32'(m_pulse));
        check("err_count_w4", 32'(err_count4), 32'(m_cnt4));
`ifdef PRBS_CHK_BITCNT_EN
        check("bit_count", 32'(bit_count), 32'(m_bc));
        check("bit_count_w4", 32'(bit_count4), 32'(m_bc4));
`endif
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit c);
        rst = r; bit_valid = v; bit_in = b; clear_err = c;
        @(posedge clk);
        model_step(r, v, b, c);
        #1;
        compare_all();
    endtask

    logic [7:0] g;
    function automatic bit gen_bit();
        bit o = ^(g & TAPS_M);
        g = {g[6:0], o};
        return o;
    endfunction

    task automatic clean();
        step(0, 1, gen_bit(), 0);
    endtask

    typedef struct {
        bit r, v, b, c;
        logic [1:0]  st;
        bit          lk;
        bit          pl;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[12];

    initial begin
        bit b;
        int guard;
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_err = 1'b0;
        model_reset();

        // Reset, idle, then the first eight bits of the generator seeded with 8'h01.
        tbl[0]  = '{1, 0, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[1]  = '{1, 0, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[2]  = '{0, 0, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[3]  = '{0, 0, 1, 1, 2'd0, 0, 0, 16'd0};
        tbl[4]  = '{0, 1, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[5]  = '{0, 1, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[6]  = '{0, 1, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[7]  = '{0, 1, 1, 0, 2'd0, 0, 0, 16'd0};
        tbl[8]  = '{0, 1, 1, 0, 2'd0, 0, 0, 16'd0};
        tbl[9]  = '{0, 1, 1, 0, 2'd0, 0, 0, 16'd0};
        tbl[10] = '{0, 1, 0, 0, 2'd0, 0, 0, 16'd0};
        tbl[11] = '{0, 1, 0, 0, 2'd1, 0, 0, 16'd0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].c);
            check($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].st));
            check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
            check($sformatf("tbl%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].pl));
            check($sformatf("tbl%0d_cnt", i), 32'(err_count), 32'(tbl[i].cnt));
        end
        g = 8'h1C;

        for (int i = 9; i <= 24; i++) begin
            clean();
            if (i == 23) check("lock_not_yet_bit23", 32'(locked), 32'd0);
            if (i == 24) begin
                check("lock_at_bit24", 32'(locked), 32'd1);
                check("state_locked", 32'(state_o), 32'd2);
            end
        end

        for (int i = 0; i < 30; i++) clean();
        step(0, 1, ~gen_bit(), 0);
        check("single_err_pulse", 32'(err_pulse), 32'd1);
        check("single_err_cnt", 32'(err_count), 32'd1);
        check("single_err_locked", 32'(locked), 32'd1);
        clean();
        check("pulse_one_cycle", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 10; i++) clean();
        check("flywheel_cnt", 32'(err_count), 32'd1);

        step(0, 0, 0, 1);
        check("clear_idle", 32'(err_count), 32'd0);
        guard = 0;
        do begin
            clean();
            guard++;
        end while (m_win != 0 && guard < 100);
        check("window_align", 32'(guard < 100), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, ~gen_bit(), 0);
            if (k < 3) begin
                check("burst_still_locked", 32'(locked), 32'd1);
                clean();
            end
        end
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_state", 32'(state_o), 32'd0);
        check("loss_cnt", 32'(err_count), 32'd3);
        for (int i = 1; i <= 24; i++) begin
            clean();
            if (i == 8)  check("relock_check", 32'(state_o), 32'd1);
            if (i == 23) check("relock_not_yet", 32'(locked), 32'd0);
            if (i == 24) check("relock", 32'(locked), 32'd1);
        end

        check("cnt_kept", 32'(err_count), 32'd3);
        step(0, 1, ~gen_bit(), 1);
        check("clear_wins_cnt", 32'(err_count), 32'd0);
        check("clear_wins_pulse", 32'(err_pulse), 32'd1);
        clean();

        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i < 39; i++) clean();
            step(0, 1, ~gen_bit(), 0);
        end
        check("sparse_cnt16", 32'(err_count), 32'd20);
        check("sparse_sat4", 32'(err_count4), 32'd15);
        check("sparse_locked", 32'(locked), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            bit r, v, c, f;
            r = ($urandom % 1500) == 0;
            v = ($urandom % 4) != 0;
            c = ($urandom % 200) == 0;
            f = ($urandom % 30) == 0;
            b = v ? gen_bit() : 1'b0;
            step(r, v, b ^ f, c);
        end

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0);
            check("zeros_state", 32'(state_o), 32'd0);
            check("zeros_locked", 32'(locked), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
